// File: rtl/seg7_seq_monitor.sv
`default_nettype none
// ============================================================================
// seg7_seq_monitor : debounces an active-low 7-seg bus, decodes it and checks
// each new digit against the odd-step sequence. Optional: SEG7_MON_ERR_STICKY_EN
// Revision : 1.0
// ============================================================================
module seg7_seq_monitor #(
  parameter int STABLE_CNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [6:0]       hex_in,
  input  logic             reverse,
`ifdef SEG7_MON_ERR_STICKY_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic [2:0]       digit,
  output logic             digit_valid,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic             invalid_pat
);

  localparam int               STAB_W    = $clog2(STABLE_CNT + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
  localparam logic [6:0]       PAT_BLANK = 7'h7F;
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  localparam logic [0:0] ST_HUNT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  logic [6:0]        cand_q, cand_d;
  logic [6:0]        acc_q, acc_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [0:0]        state_q, state_d;
  logic [2:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              seq_err_q, seq_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              invalid_q, invalid_d;

  logic              commit;
  logic [2:0]        dec_digit;
  logic              dec_ok;
  logic              dec_blank;
  logic [2:0]        exp_digit;

  function automatic logic [2:0] next_digit(input logic [2:0] d, input logic rev);
    logic [2:0] n;
    n = 3'd0;
    if (!rev) begin
      case (d)
        3'd0:    n = 3'd1;
        3'd1:    n = 3'd3;
        3'd3:    n = 3'd5;
        3'd5:    n = 3'd7;
        default: n = 3'd0;
      endcase
    end else begin
      case (d)
        3'd0:    n = 3'd7;
        3'd7:    n = 3'd5;
        3'd5:    n = 3'd3;
        3'd3:    n = 3'd1;
        default: n = 3'd0;
      endcase
    end
    return n;
  endfunction

  // Decode always looks at the candidate: it is what gets committed.
  always_comb begin
    dec_digit = 3'd0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (cand_q)
      7'h40:   dec_digit = 3'd0;
      7'h79:   dec_digit = 3'd1;
      7'h24:   dec_digit = 3'd2;
      7'h30:   dec_digit = 3'd3;
      7'h19:   dec_digit = 3'd4;
      7'h12:   dec_digit = 3'd5;
      7'h02:   dec_digit = 3'd6;
      7'h78:   dec_digit = 3'd7;
      PAT_BLANK: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (sample_en) begin
      if (hex_in == cand_q) begin
        if (stab_q < STAB_MAX) begin
          stab_d = stab_q + STAB_ONE;
        end
      end else begin
        cand_d = hex_in;
        stab_d = STAB_ONE;
      end
    end
  end

  assign commit    = sample_en && (stab_q == STAB_MAX) && (cand_q != acc_q);
  assign exp_digit = next_digit(digit_q, reverse);

  always_comb begin
    acc_d         = acc_q;
    state_d       = state_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    seq_err_d     = 1'b0;
    invalid_d     = invalid_q;
    if (commit) begin
      acc_d = cand_q;
      if (dec_ok) begin
        digit_d       = dec_digit;
        digit_valid_d = 1'b1;
        invalid_d     = 1'b0;
        // A mismatch resyncs onto the received digit rather than dropping lock.
        if ((state_q == ST_TRACK) && (dec_digit != exp_digit)) begin
          seq_err_d = 1'b1;
        end
        state_d = ST_TRACK;
      end else if (dec_blank) begin
        invalid_d = 1'b0;
        state_d   = ST_HUNT;
      end else begin
        invalid_d = 1'b1;
        if (state_q == ST_TRACK) begin
          seq_err_d = 1'b1;
        end
        state_d = ST_HUNT;
      end
    end
  end

`ifdef SEG7_MON_ERR_STICKY_EN
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end else if (seq_err_d) begin
      err_sticky_d = 1'b1;
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`else
  always_comb begin
    err_count_d = err_count_q;
    if (seq_err_d && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q        <= PAT_BLANK;
      acc_q         <= PAT_BLANK;
      stab_q        <= '0;
      state_q       <= ST_HUNT;
      digit_q       <= 3'd0;
      digit_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
      invalid_q     <= 1'b0;
    end else begin
      cand_q        <= cand_d;
      acc_q         <= acc_d;
      stab_q        <= stab_d;
      state_q       <= state_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      seq_err_q     <= seq_err_d;
      err_count_q   <= err_count_d;
      invalid_q     <= invalid_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign locked      = (state_q == ST_TRACK);
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;
  assign invalid_pat = invalid_q;

endmodule
`default_nettype wire
